// File: rtl/svi_ser_pkg.sv
// rtl/svi_ser_pkg.sv - shared constants, state enum and counter type for the slice serializer
package svi_ser_pkg;

    localparam int DATA_W  = 8;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_e;

    typedef logic [2:0] cnt_t;

endpackage

// File: rtl/I.sv
// rtl/I.sv - single-bit storage interface replicated into arrays by the slice paths
interface I;
    logic x;
endinterface

// File: rtl/svi_slice_serializer.sv
// rtl/svi_slice_serializer.sv - byte to serial bitstream via a nibble-sliced array of I instances
// Optional trailing even-parity bit when SVI_SER_PARITY_EN is defined.
module svi_slice_serializer
    import svi_ser_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_x,
    output logic              o_valid,
    output logic              o_first,
    output logic              o_last
);

`ifdef SVI_SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic              x_d, valid_d, first_d, last_d;
    logic              xfer;
    logic [DATA_W-1:0] x_bits;

    I u_I [DATA_W-1:0] ();

    assign o_ready = !i_rst && ((state_q == S_IDLE) || (state_q == S_PARITY) ||
                                ((state_q == S_SHIFT) && (cnt_q == 3'd0) && !PAR_EN));
    assign xfer    = i_valid && o_ready;

    // Upper and lower slices are loaded independently; the bit on o_x is already in a flop.
    for (genvar g = SLICE_W; g < DATA_W; g++) begin : g_upper
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)     u_I[g].x <= 1'b0;
            else if (xfer) u_I[g].x <= i_a[g];
        end
        assign x_bits[g] = u_I[g].x;
    end

    for (genvar g = 0; g < SLICE_W; g++) begin : g_lower
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)     u_I[g].x <= 1'b0;
            else if (xfer) u_I[g].x <= i_a[g];
        end
        assign x_bits[g] = u_I[g].x;
    end

`ifdef SVI_SER_PARITY_EN
    logic par_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     par_q <= 1'b0;
        else if (xfer) par_q <= ^i_a;
    end
`endif

    // state/cnt describe the bit currently on o_x; a transfer bypasses u_I for the MSB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (xfer) begin
            state_d = S_SHIFT;
            cnt_d   = 3'd7;
            x_d     = i_a[DATA_W-1];
            valid_d = 1'b1;
            first_d = 1'b1;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_d   = cnt_q - 3'd1;
                        x_d     = x_bits[cnt_d];
                        valid_d = 1'b1;
                        last_d  = (cnt_d == 3'd0) && !PAR_EN;
                    end else begin
`ifdef SVI_SER_PARITY_EN
                        state_d = S_PARITY;
                        x_d     = par_q;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
`else
                        state_d = S_IDLE;
                        cnt_d   = 3'd7;
`endif
                    end
                end
                S_PARITY: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd7;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd7;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd7;
            o_x     <= 1'b0;
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_x     <= x_d;
            o_valid <= valid_d;
            o_first <= first_d;
            o_last  <= last_d;
        end
    end

endmodule

// File: tb/tb_svi_slice_serializer.sv
// tb/tb_svi_slice_serializer.sv - scoreboard bench for svi_slice_serializer (honours SVI_SER_PARITY_EN)
module tb_svi_slice_serializer;

`ifdef SVI_SER_PARITY_EN
    localparam int  FRAME = 9;
    localparam bit  PAR   = 1'b1;
`else
    localparam int  FRAME = 8;
    localparam bit  PAR   = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_a;
    logic       i_valid;
    logic       o_ready, o_x, o_valid, o_first, o_last;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];

    svi_slice_serializer dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_a    (i_a),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_x    (o_x),
        .o_valid(o_valid),
        .o_first(o_first),
        .o_last (o_last)
    );

    always #5 i_clk = ~i_clk;

    // Entry = {x, first, last} for each frame bit, in transmit order.
    function automatic void push_frame(input logic [7:0] a);
        for (int i = 7; i >= 0; i--)
            sb.push_back({a[i], i == 7, (i == 0) && !PAR});
        if (PAR) sb.push_back({^a, 1'b0, 1'b1});
    endfunction

    always @(negedge i_clk) begin
        if (o_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL monitor_unexpected_bit got {x,first,last}=%b expected none", {o_x, o_first, o_last});
            end else begin
                logic [2:0] e;
                e = sb.pop_front();
                if ({o_x, o_first, o_last} !== e) begin
                    errors++;
                    $display("FAIL monitor_bit got {x,first,last}=%b expected %b", {o_x, o_first, o_last}, e);
                end
            end
        end
    end

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_a = 8'h00;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_ready, o_x, o_valid, o_first, o_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00000", {o_ready, o_x, o_valid, o_first, o_last});
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got ready=%b valid=%b expected 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_single();
        i_valid = 1'b1; i_a = 8'hA5; push_frame(8'hA5);
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            if (k == 1) begin
                checks++;
                if (o_first !== 1'b1 || o_x !== 1'b1) begin
                    errors++;
                    $display("FAIL single_first got first=%b x=%b expected 1 1", o_first, o_x);
                end
            end
            if (k == FRAME) begin
                checks++;
                if (o_last !== 1'b1) begin
                    errors++;
                    $display("FAIL single_last got %b expected 1", o_last);
                end
            end
        end
        checks++;
        if (o_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_end got valid=%b pending=%0d expected 0 0", o_valid, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_c0 got %b expected 1", o_ready);
        end
        i_valid = 1'b1; i_a = 8'hF0; push_frame(8'hF0);
        for (int c = 1; c <= 2 * FRAME; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_ready !== (c % FRAME == 0) || o_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_cycle%0d got ready=%b valid=%b expected %b 1", c, o_ready, o_valid, c % FRAME == 0);
            end
            if (c == FRAME) begin
                i_a = 8'h0F; push_frame(8'h0F);
            end
            if (c == 2 * FRAME) i_valid = 1'b0;
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_end got valid=%b pending=%0d expected 0 0", o_valid, sb.size());
        end
    endtask

    task automatic test_hold_busy();
        i_valid = 1'b1; i_a = 8'h3C; push_frame(8'h3C);
        for (int c = 1; c < FRAME; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready_c%0d got %b expected 0", c, o_ready);
            end
            i_a = 8'($urandom);
        end
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready_end got %b expected 1", o_ready);
        end
        i_a = 8'h5A; push_frame(8'h5A);
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int k = 0; k < 3 * FRAME && sb.size() != 0; k++) @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (sb.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_drain got pending=%0d valid=%b expected 0 0", sb.size(), o_valid);
        end
    endtask

    task automatic test_reset_mid();
        i_valid = 1'b1; i_a = 8'hFF; push_frame(8'hFF);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if ({o_ready, o_x, o_valid, o_first, o_last} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs got %b expected 00000", {o_ready, o_x, o_valid, o_first, o_last});
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_after_c%0d got valid=%b expected 0", k, o_valid);
            end
        end
    endtask

    task automatic test_frames(input logic [7:0] a, input logic [7:0] b, input string name);
        i_valid = 1'b1; i_a = a; push_frame(a);
        repeat (FRAME) @(negedge i_clk);
        i_a = b; push_frame(b);
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int k = 0; k < 3 * FRAME && sb.size() != 0; k++) @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (sb.size() != 0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d valid=%b expected 0 0", name, sb.size(), o_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_busy();
        test_reset_mid();
        test_frames(8'h07, 8'h03, "parity");
        test_frames(8'h80, 8'h01, "slice");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
